// File: rtl/rv_core_pkg.sv
// Shared core definitions: data width, register count, register index type
// and the writeback grant encoding used by the round-robin arbiter.
package rv_core_pkg;

   localparam int XLEN = 64;
   localparam int NREG = 32;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] belong to the ALU, req[1]/gnt[1]
// to the load unit. A lone requester is always granted; on contention the
// requester that did not win the most recent grant goes first. Every grant is
// an acceptance, so the last-grant state follows gnt directly.
module rr_arb2
   import rv_core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   grant_e last_grant;

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      gnt = 2'b00;
      if (!reset) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Remember the winner; after reset the LSU counts as last, so the ALU wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GNT_LSU;
      end else if (gnt[0]) begin
         last_grant <= GNT_ALU;
      end else if (gnt[1]) begin
         last_grant <= GNT_LSU;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
// Merges ALU and load-unit writebacks onto one registered register-file write
// port, and tracks which registers have a writeback pending so the issue
// stage can detect operand hazards.
// Optional feature: define RF_WB_FWD_EN to add forwarding outputs that expose
// the registered write as a bypass source for rs1/rs2.
module regfile_wb_arbiter #(
   parameter int XLEN = rv_core_pkg::XLEN,
   parameter int NREG = rv_core_pkg::NREG
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            hazard
`ifdef RF_WB_FWD_EN
   ,
   output logic            fwd1_valid,
   output logic [XLEN-1:0] fwd1_data,
   output logic            fwd2_valid,
   output logic [XLEN-1:0] fwd2_data
`endif
);

   import rv_core_pkg::*;

   logic [1:0]      gnt;
   logic            accept;
   reg_idx_t        acc_rd;
   logic [XLEN-1:0] acc_data;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({lsu_valid, alu_valid}),
      .gnt   (gnt)
   );

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];
   assign accept    = |gnt;

   // Route the winning requester's destination and data toward the write port.
   always_comb begin
      acc_rd   = alu_rd;
      acc_data = alu_data;
      if (gnt[1]) begin
         acc_rd   = lsu_rd;
         acc_data = lsu_data;
      end
   end

   // Register the accepted write; writes to x0 are consumed but never enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
      end else if (accept) begin
         rf_we    <= (acc_rd != 5'd0);
         rf_rd    <= acc_rd;
         rf_wdata <= acc_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   // Scoreboard update: an accepted writeback clears its register, a new
   // reservation sets it, and the reservation is applied last so it wins.
   always_comb begin
      busy_next = busy;
      if (accept) begin
         busy_next[acc_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         busy_next[issue_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Scoreboard state; x0 can never become busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Hazard looks only at the registered scoreboard, so a clear in this cycle
   // is not visible until the next one.
   always_comb begin
      hazard = busy[rs1] | busy[rs2] |
               (issue_valid & (issue_rd != 5'd0) & busy[issue_rd]);
   end

`ifdef RF_WB_FWD_EN
   // Bypass the registered write to whichever source operand names it.
   always_comb begin
      fwd1_valid = rf_we & (rf_rd == rs1) & (rs1 != 5'd0);
      fwd2_valid = rf_we & (rf_rd == rs2) & (rs2 != 5'd0);
      fwd1_data  = rf_wdata;
      fwd2_data  = rf_wdata;
   end
`endif

endmodule
